// File: rtl/intc_pkg.sv
// Shared constants for the intc_pic interrupt controller: register map,
// FSM state encoding and default sizing.
package intc_pkg;

  localparam int unsigned INTC_NUM_IRQ = 8;
  localparam int unsigned INTC_ID_W    = 3;

  localparam logic [1:0] INTC_A_MASK = 2'd0;
  localparam logic [1:0] INTC_A_PEND = 2'd1;
  localparam logic [1:0] INTC_A_ID   = 2'd2;
  localparam logic [1:0] INTC_A_EOI  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } intc_state_t;

endpackage

// File: rtl/intc_prio_enc.sv
// Combinational priority encoder: reports the lowest set index of vec.
module intc_prio_enc
  import intc_pkg::*;
#(
  parameter int unsigned N = INTC_NUM_IRQ,
  parameter int unsigned W = INTC_ID_W
) (
  input  logic [N-1:0] vec,
  output logic         found_c,
  output logic [W-1:0] idx_c
);

  // Scan high to low so the lowest set index is the last assignment.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        found_c = 1'b1;
        idx_c   = W'(i);
      end
    end
  end

endmodule

// File: rtl/intc_pic.sv
// Programmable interrupt controller on the device side of intr/inta.
// Define INTC_NESTING_EN to let higher-priority sources preempt in-service ones.
module intc_pic
  import intc_pkg::*;
#(
  parameter int unsigned NUM_IRQ = INTC_NUM_IRQ,
  parameter int unsigned ID_W    = INTC_ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               inta,
  output logic               intr,
  input  logic               sel,
  input  logic               we,
  input  logic [1:0]         addr,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  intc_state_t        state, state_nx;
  logic [NUM_IRQ-1:0] sync1, sync2, hist;
  logic [NUM_IRQ-1:0] pending, pend_nx;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] isr, isr_nx;
  logic [ID_W-1:0]    cur_id;
  logic               id_valid;

  logic [NUM_IRQ-1:0] rise_c, req_vec_c;
  logic               req_found_c, isr_found_c, eligible_c, commit_c;
  logic [ID_W-1:0]    win_c, isr_idx_c;
  logic               wr_mask_c, wr_pend_c, wr_eoi_c;
  logic               wdata_unused;

  assign rise_c    = sync2 & ~hist;
  assign req_vec_c = pending & ~mask;
  assign wr_mask_c = sel && we && (addr == INTC_A_MASK);
  assign wr_pend_c = sel && we && (addr == INTC_A_PEND);
  assign wr_eoi_c  = sel && we && (addr == INTC_A_EOI);
  assign wdata_unused = ^wdata;

  intc_prio_enc #(.N(NUM_IRQ), .W(ID_W)) u_req_enc (
    .vec     (req_vec_c),
    .found_c (req_found_c),
    .idx_c   (win_c)
  );

  intc_prio_enc #(.N(NUM_IRQ), .W(ID_W)) u_isr_enc (
    .vec     (isr),
    .found_c (isr_found_c),
    .idx_c   (isr_idx_c)
  );

`ifdef INTC_NESTING_EN
  assign eligible_c = req_found_c && (!isr_found_c || (win_c < isr_idx_c));
`else
  assign eligible_c = req_found_c && !isr_found_c;
`endif

  // Handshake FSM; commit only when the request is still eligible.
  always_comb begin
    state_nx = state;
    commit_c = 1'b0;
    case (state)
      IDLE: if (eligible_c) state_nx = REQ;
      REQ: begin
        if (inta && eligible_c) begin
          commit_c = 1'b1;
          state_nx = ACK;
        end else if (!eligible_c) begin
          state_nx = IDLE;
        end
      end
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Pending: W1C and commit clear first, a fresh edge always wins.
  always_comb begin
    pend_nx = pending;
    if (wr_pend_c) pend_nx = pend_nx & ~wdata[NUM_IRQ-1:0];
    if (commit_c)  pend_nx[win_c] = 1'b0;
    pend_nx = pend_nx | rise_c;
  end

  // In-service: EOI retires the prior top bit before a new commit lands.
  always_comb begin
    isr_nx = isr;
    if (wr_eoi_c && isr_found_c) isr_nx[isr_idx_c] = 1'b0;
    if (commit_c)                isr_nx[win_c]     = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      intr     <= 1'b0;
      sync1    <= '0;
      sync2    <= '0;
      hist     <= '0;
      pending  <= '0;
      mask     <= '1;
      isr      <= '0;
      cur_id   <= '0;
      id_valid <= 1'b0;
    end else begin
      state   <= state_nx;
      intr    <= (state_nx == REQ);
      sync1   <= irq;
      sync2   <= sync1;
      hist    <= sync2;
      pending <= pend_nx;
      isr     <= isr_nx;
      if (wr_mask_c) mask <= wdata[NUM_IRQ-1:0];
      if (commit_c) begin
        cur_id   <= win_c;
        id_valid <= 1'b1;
      end else if (wr_eoi_c && (isr_nx == '0)) begin
        id_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (addr)
        INTC_A_MASK: rdata[NUM_IRQ-1:0] = mask;
        INTC_A_PEND: rdata[NUM_IRQ-1:0] = pending;
        INTC_A_ID: begin
          rdata[31]       = id_valid;
          rdata[ID_W-1:0] = cur_id;
        end
        INTC_A_EOI:  rdata[NUM_IRQ-1:0] = isr;
        default:     rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_intc_pic.sv
// Self-checking bench for intc_pic: per-cycle vector tables with a queue
// scoreboard for intr and register reads.
module tb_intc_pic;

  logic        clk;
  logic        rst;
  logic [7:0]  irq;
  logic        inta;
  logic        intr;
  logic        sel;
  logic        we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic        rst;
    logic [7:0]  irq;
    logic        inta;
    logic        sel;
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        xi;
    logic        chk;
    logic [31:0] xrd;
  } vec_t;

  typedef struct {
    string       name;
    bit          kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[$];

  intc_pic #(.NUM_IRQ(8), .ID_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .irq   (irq),
    .inta  (inta),
    .intr  (intr),
    .sel   (sel),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  function automatic vec_t mk(input logic r, input logic [7:0] i, input logic a,
                              input logic s, input logic w, input logic [1:0] ad,
                              input logic [31:0] wd, input logic xi, input logic c,
                              input logic [31:0] xrd);
    vec_t v;
    v.rst = r; v.irq = i; v.inta = a; v.sel = s; v.we = w; v.addr = ad;
    v.wdata = wd; v.xi = xi; v.chk = c; v.xrd = xrd;
    return v;
  endfunction

  // Drive one cycle of inputs, queue expectations, compare after the edge.
  task automatic apply(input vec_t v, input string tag);
    exp_t        e;
    logic [31:0] act;
    @(negedge clk);
    rst = v.rst; irq = v.irq; inta = v.inta; sel = v.sel; we = v.we;
    addr = v.addr; wdata = v.wdata;
    e.name = {tag, "_intr"}; e.kind = 1'b0; e.exp = {31'd0, v.xi};
    sbq.push_back(e);
    if (v.chk) begin
      e.name = {tag, "_rdata"}; e.kind = 1'b1; e.exp = v.xrd;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      act = e.kind ? rdata : {31'd0, intr};
      checks++;
      if (act === e.exp) passed++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", e.name, act, e.exp);
    end
  endtask

  task automatic run(input vec_t q[$], input string tag);
    for (int i = 0; i < q.size(); i++) apply(q[i], $sformatf("%s%0d", tag, i));
  endtask

  initial begin
    vec_t sa[$];
    vec_t sb[$];
    rst = 1'b1; irq = '0; inta = 1'b0; sel = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    // Reset, single source, multi-cycle inta counted once
    tbl.push_back(mk(1, 8'h00, 0, 1, 0, 0, 32'h00, 0, 1, 32'h000000FF));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'hFE, 0, 1, 32'h000000FE));
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h01, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h01, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000001));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 1, 1, 32'h00000001));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 2, 32'h00, 0, 1, 32'h80000000));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 1, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 3, 32'h00, 0, 1, 32'h00000001));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 3, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 2, 32'h00, 0, 1, 32'h00000000));
    // Two simultaneous sources, lower index wins, second served after EOI
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h24, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    tbl.push_back(mk(0, 8'h24, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    tbl.push_back(mk(0, 8'h24, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000024));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 1, 1, 32'h00000024));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 2, 32'h00, 0, 1, 32'h80000002));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000020));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 3, 32'h00, 0, 1, 32'h00000004));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 3, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 2, 32'h00, 1, 1, 32'h00000002));
    tbl.push_back(mk(0, 8'h00, 1, 1, 0, 2, 32'h00, 0, 1, 32'h80000005));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 3, 32'h00, 0, 1, 32'h00000000));
    // Mask during REQ withdraws the request without an acknowledge
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'hFE, 0, 1, 32'h000000FE));
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    tbl.push_back(mk(0, 8'h01, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000001));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 1, 1, 32'h00000001));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'hFF, 1, 1, 32'h000000FF));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000001));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 3, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'h01, 0, 1, 32'h00000000));
    // W1C colliding with a new edge on the same line: set wins
    tbl.push_back(mk(0, 8'h08, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    tbl.push_back(mk(0, 8'h08, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    tbl.push_back(mk(0, 8'h08, 0, 1, 1, 1, 32'h08, 0, 1, 32'h00000008));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 1, 32'h08, 0, 1, 32'h00000000));
    // Reset mid-handshake with inta asserted
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'hFE, 0, 1, 32'h000000FE));
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    tbl.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    tbl.push_back(mk(0, 8'h01, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000001));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 1, 1, 32'h00000001));
    tbl.push_back(mk(1, 8'h00, 1, 1, 0, 2, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 0, 32'h00, 0, 1, 32'h000000FF));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000000));
    tbl.push_back(mk(0, 8'h00, 0, 1, 0, 3, 32'h00, 0, 1, 32'h00000000));
    run(tbl, "tbl");

    // New edge on line 0 landing in the same cycle as its commit
    sa.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'hFE, 0, 1, 32'h000000FE));
    sa.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    sa.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    sa.push_back(mk(0, 8'h01, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000001));
    sa.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h00, 1, 0, 32'h00000000));
    sa.push_back(mk(0, 8'h00, 0, 0, 0, 0, 32'h00, 1, 0, 32'h00000000));
    sa.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 1, 0, 32'h00000000));
    sa.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 1, 0, 32'h00000000));
    sa.push_back(mk(0, 8'h01, 1, 1, 0, 1, 32'h00, 0, 1, 32'h00000001));
    sa.push_back(mk(0, 8'h01, 0, 1, 0, 3, 32'h00, 0, 1, 32'h00000001));
    sa.push_back(mk(0, 8'h01, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000001));
    sa.push_back(mk(0, 8'h01, 0, 1, 1, 3, 32'h00, 0, 1, 32'h00000000));
    sa.push_back(mk(0, 8'h01, 0, 0, 0, 0, 32'h00, 1, 0, 32'h00000000));
    sa.push_back(mk(0, 8'h01, 1, 1, 0, 1, 32'h00, 0, 1, 32'h00000000));
    sa.push_back(mk(0, 8'h01, 0, 1, 1, 3, 32'h00, 0, 1, 32'h00000000));
    sa.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'hFF, 0, 1, 32'h000000FF));
    run(sa, "edge_commit");

    // Source 4 in service, then source 1 arrives
    sb.push_back(mk(0, 8'h00, 0, 1, 1, 0, 32'h00, 0, 1, 32'h00000000));
    sb.push_back(mk(0, 8'h10, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    sb.push_back(mk(0, 8'h10, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    sb.push_back(mk(0, 8'h10, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000010));
    sb.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 1, 1, 32'h00000010));
    sb.push_back(mk(0, 8'h00, 1, 1, 0, 2, 32'h00, 0, 1, 32'h80000004));
    sb.push_back(mk(0, 8'h02, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    sb.push_back(mk(0, 8'h02, 0, 0, 0, 0, 32'h00, 0, 0, 32'h00000000));
    sb.push_back(mk(0, 8'h02, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000002));
`ifdef INTC_NESTING_EN
    sb.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 1, 1, 32'h00000002));
    sb.push_back(mk(0, 8'h00, 1, 1, 0, 3, 32'h00, 0, 1, 32'h00000012));
    sb.push_back(mk(0, 8'h00, 0, 1, 0, 2, 32'h00, 0, 1, 32'h80000001));
    sb.push_back(mk(0, 8'h00, 0, 1, 1, 3, 32'h00, 0, 1, 32'h00000010));
    sb.push_back(mk(0, 8'h00, 0, 1, 0, 2, 32'h00, 0, 1, 32'h80000001));
    sb.push_back(mk(0, 8'h00, 0, 1, 1, 3, 32'h00, 0, 1, 32'h00000000));
    sb.push_back(mk(0, 8'h00, 0, 1, 0, 2, 32'h00, 0, 1, 32'h00000001));
`else
    sb.push_back(mk(0, 8'h00, 0, 1, 0, 1, 32'h00, 0, 1, 32'h00000002));
    sb.push_back(mk(0, 8'h00, 1, 1, 0, 3, 32'h00, 0, 1, 32'h00000010));
    sb.push_back(mk(0, 8'h00, 0, 1, 1, 3, 32'h00, 0, 1, 32'h00000000));
    sb.push_back(mk(0, 8'h00, 0, 1, 0, 2, 32'h00, 1, 1, 32'h00000004));
    sb.push_back(mk(0, 8'h00, 1, 1, 0, 2, 32'h00, 0, 1, 32'h80000001));
    sb.push_back(mk(0, 8'h00, 0, 1, 1, 3, 32'h00, 0, 1, 32'h00000000));
    sb.push_back(mk(0, 8'h00, 0, 1, 0, 2, 32'h00, 0, 1, 32'h00000001));
`endif
    run(sb, "prio");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/intc_pic.md
Name: intc_pic

Overview:
- Programmable interrupt controller on the device side of the CPU's intr/inta handshake.
- Synchronises and edge-detects external IRQ lines and latches them as pending; pending lines are prioritised against mask and in-service state.
- Raises intr and, on inta, commits the winning source to in-service.
- The handler reads the source ID and writes end-of-interrupt (EOI) over a small memory-mapped register port.

Parameters:
- NUM_IRQ, 8, number of external interrupt lines (2..16); index 0 is highest priority.
- ID_W, 3, width of the source ID; must equal ceil(log2(NUM_IRQ)).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- irq  in  NUM_IRQ  asynchronous external requests, rising-edge triggered
- inta  in  1  interrupt acknowledge from CPU control; may be held high for several cycles
- intr  out  1  interrupt request to CPU control
- sel  in  1  register port select
- we  in  1  register write enable, qualified by sel
- addr  in  2  register index
- wdata  in  32  write data
- rdata  out  32  combinational read data; 0 when sel=0

Behaviour:
- Reset (one cycle of rst=1):
  - intr=0, state=IDLE.
  - pending, isr, sync flops and edge-history flops are all cleared.
  - mask is all ones (every line masked).
  - cur_id=0, id_valid=0.
- Input path:
  - Each irq bit passes through a 2-flop synchroniser plus one history flop.
  - A rising edge sets its pending bit. If irq first rises before edge 0, pending=1 after edge 2.
- Registers:
  - addr 0 MASK: R/W, bits [NUM_IRQ-1:0]; 1 = masked.
  - addr 1 PENDING: read; write-1-to-clear.
  - addr 2 ID: read-only; returns {id_valid at bit31, zeros, cur_id}.
  - addr 3 EOI: write of any value clears the highest-priority (lowest-index) isr bit; if isr becomes 0, id_valid clears. Reads of addr 3 return isr.
- Eligibility:
  - req_vec = pending & ~mask.
  - win = lowest set index of req_vec.
  - eligible when req_vec≠0 and the gating rule (see Optional Feature) passes.
- FSM (registered):
  - IDLE: intr=0. Goes to REQ next cycle if eligible.
  - REQ: intr=1.
    - If inta=1: pending[win]←0, isr[win]←1, cur_id←win, id_valid←1; go to ACK.
    - Else if not eligible (masked or cleared meanwhile): go to IDLE, intr drops next cycle.
  - ACK: intr=0 for exactly one cycle; inta is ignored here; go to IDLE.
  - Net effect: a multi-cycle inta is counted once, and a back-to-back request needs at least 3 cycles.
- win in REQ may change cycle to cycle as higher-priority requests arrive; the value latched is the one current in the inta cycle.
- Simultaneous events:
  - An edge setting pending[i] in the same cycle as a W1C of bit i: set wins.
  - An edge on line i in the same cycle as its inta commit: pending[i] stays 1 (new edge kept).
  - EOI in the same cycle as inta commit: EOI clears the prior highest isr bit first, then the new bit is set.
- Mask written to 1 during REQ for the winning line: the request withdraws via the REQ→IDLE path; no acknowledge is recorded.
- inta while in IDLE or ACK: no effect.
- rst asserted mid-handshake: everything returns to reset values on that edge; an in-flight inta is discarded.

Optional Feature:
- Macro INTC_NESTING_EN.
- Defined: gating rule is win index < lowest set isr index, or isr==0. A higher-priority source preempts an in-service one and isr holds multiple bits.
- Undefined: gating rule is isr==0. At most one isr bit is ever set, and intr is suppressed until EOI.

Decomposition:
- Package intc_pkg holds:
  - register address constants (INTC_A_MASK=0, INTC_A_PEND=1, INTC_A_ID=2, INTC_A_EOI=3);
  - FSM state encoding (IDLE, REQ, ACK);
  - default NUM_IRQ/ID_W.
- One sub-module intc_prio_enc: combinational lowest-index-first encoder returning {found, index}. Instantiated twice: once for req_vec, once for isr.

Test Plan:
- Reset, write MASK=0xFE, pulse irq[0] → PENDING=0x01 after edge 2, intr=1 after edge 3; inta held 3 cycles → one commit, ID=0x80000000, intr low for ACK then stays 0, PENDING=0.
- MASK=0x00; irq[5] and irq[2] rise in the same cycle; inta → ID reads 2, PENDING=0x20. Without INTC_NESTING_EN, intr stays 0 until an EOI write, then rises for source 5.
- With INTC_NESTING_EN: source 4 in service; irq[1] rises → intr reasserts, inta → isr=0x12, cur_id=1. Two EOI writes → isr 0x10, then 0x00 with id_valid=0.
- Request in REQ; write MASK=0xFF before inta → intr falls the next cycle, PENDING still 0x01, isr=0.
- W1C of PENDING bit 3 in the same cycle as a new irq[3] edge → PENDING bit 3 remains 1.
- Assert rst while in REQ with inta=1 → intr=0, MASK=0xFF, PENDING=0, isr=0, ID=0.
